// File: rtl/pcr_mix_sequencer_pkg.sv
// Shared types and defaults for the reagent mixing sequencer: FSM state encoding,
// default parameter values and the per-channel volume slicing helper.
package pcr_mix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SELECT = 3'd2,
        ST_PUMP   = 3'd3,
        ST_DWELL  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_THERM  = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    localparam int DEF_N_REAGENTS = 6;
    localparam int DEF_VOL_W      = 8;
    localparam int DEF_DWELL_W    = 16;
    localparam int DEF_CYC_W      = 6;
    localparam int DEF_SETTLE     = 2;

    // Widest supported configuration: 16 channels of up to 16-bit volumes.
    localparam int VOL_MAX_W        = 16;
    localparam int VOL_CFG_MAX_BITS = 16 * VOL_MAX_W;

    function automatic logic [VOL_MAX_W-1:0] vol_slice(
        input logic [VOL_CFG_MAX_BITS-1:0] cfg,
        input int unsigned                 ch,
        input int unsigned                 vol_w
    );
        logic [VOL_CFG_MAX_BITS-1:0] w_shifted;
        logic [VOL_MAX_W-1:0]        w_mask;
        w_shifted = cfg >> (ch * vol_w);
        w_mask    = (VOL_MAX_W'(1) << vol_w) - VOL_MAX_W'(1);
        return w_shifted[VOL_MAX_W-1:0] & w_mask;
    endfunction

endpackage

// File: rtl/pcr_mix_sequencer_down_counter.sv
// Loadable down-counter that saturates at zero; used for valve settle time,
// remaining pump pulses and mix dwell.
module pcr_down_counter
    import pcr_mix_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pcr_mix_sequencer.sv
// Serial reagent mixing sequencer: per-channel valve/pump injection, mix dwell and
// an optional thermal-cycling stage compiled in with PCR_MIX_THERMAL_EN.
module pcr_mix_sequencer
    import pcr_mix_pkg::*;
#(
    parameter int N_REAGENTS = DEF_N_REAGENTS,
    parameter int VOL_W      = DEF_VOL_W,
    parameter int DWELL_W    = DEF_DWELL_W,
    parameter int CYC_W      = DEF_CYC_W,
    parameter int SETTLE     = DEF_SETTLE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [N_REAGENTS*VOL_W-1:0]   vol_cfg,
    input  logic [DWELL_W-1:0]            dwell_cfg,
    input  logic [CYC_W-1:0]              n_cycles,
    input  logic                          pump_ready,
    input  logic                          thermal_ack,
    output logic [N_REAGENTS-1:0]         valve_sel,
    output logic                          pump_pulse,
    output logic                          thermal_req,
    output logic                          busy,
    output logic [$clog2(N_REAGENTS)-1:0] cur_ch,
    output logic [CYC_W-1:0]              cycle_cnt,
    output logic                          done,
    output logic                          aborted
);

    localparam int CH_W  = $clog2(N_REAGENTS);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t r_state;
    state_t w_state_next;

    logic [N_REAGENTS*VOL_W-1:0]  r_vol_cfg;
    logic [DWELL_W-1:0]           r_dwell;
    logic [CH_W-1:0]              r_cur_ch;
    logic [N_REAGENTS-1:0]        r_valve_sel;
    logic                         r_pump_pulse;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_aborted;

    logic [VOL_CFG_MAX_BITS-1:0]  w_cfg_ext;
    logic [VOL_W-1:0]             w_vol [N_REAGENTS];
    logic [VOL_W-1:0]             w_vol_cur;
    logic [VOL_W-1:0]             w_vol_next;
    logic [CH_W-1:0]              w_ch_next;
    logic [N_REAGENTS-1:0]        w_onehot_next;
    logic [DWELL_W-1:0]           w_dwell_load_val;
    logic                         w_valve_open;
    logic                         w_sel_load;
    logic                         w_settle_dec;
    logic                         w_pump_dec;
    logic                         w_dwell_load;
    logic                         w_dwell_dec;
    logic                         w_pulse_next;
    logic                         w_done_next;
    logic                         w_abort_take;
    logic                         w_settle_zero;
    logic                         w_rem_zero;
    logic                         w_dwell_zero;

`ifdef PCR_MIX_THERMAL_EN
    logic [CYC_W-1:0]             r_n_cycles;
    logic [CYC_W-1:0]             r_cycle_cnt;
    logic                         r_therm_req;
    logic                         w_therm_inc;
    logic                         w_req_next;
`else
    logic                         w_unused;
    assign w_unused = &{1'b0, thermal_ack, n_cycles};
`endif

    // Zero-extend the latched volume vector so the shared slicing helper can be used.
    always_comb begin
        w_cfg_ext = '0;
        w_cfg_ext[N_REAGENTS*VOL_W-1:0] = r_vol_cfg;
    end

    generate
        for (genvar gi = 0; gi < N_REAGENTS; gi++) begin : g_vol
            assign w_vol[gi] = VOL_W'(vol_slice(w_cfg_ext, gi, VOL_W));
        end
    endgenerate

    assign w_vol_cur        = w_vol[r_cur_ch];
    assign w_vol_next       = w_vol[w_ch_next];
    assign w_onehot_next    = N_REAGENTS'(1) << w_ch_next;
    assign w_dwell_load_val = (r_dwell == '0) ? '0 : (r_dwell - DWELL_W'(1));

    pcr_down_counter #(.W(SET_W)) u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_sel_load),
        .i_load_val (SET_W'(SETTLE - 1)),
        .i_dec      (w_settle_dec),
        .o_zero     (w_settle_zero)
    );

    pcr_down_counter #(.W(VOL_W)) u_pulse_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_sel_load),
        .i_load_val (w_vol_next),
        .i_dec      (w_pump_dec),
        .o_zero     (w_rem_zero)
    );

    pcr_down_counter #(.W(DWELL_W)) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_dwell_load),
        .i_load_val (w_dwell_load_val),
        .i_dec      (w_dwell_dec),
        .o_zero     (w_dwell_zero)
    );

    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_cur_ch;
        w_sel_load   = 1'b0;
        w_settle_dec = 1'b0;
        w_pump_dec   = 1'b0;
        w_dwell_load = 1'b0;
        w_dwell_dec  = 1'b0;
        w_pulse_next = 1'b0;
        w_abort_take = 1'b0;
`ifdef PCR_MIX_THERMAL_EN
        w_therm_inc  = 1'b0;
        w_req_next   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ch_next    = '0;
                w_sel_load   = 1'b1;
                w_state_next = ST_SELECT;
            end
            ST_SELECT: begin
                if (w_vol_cur == '0) begin
                    w_state_next = ST_NEXT;
                end else if (w_settle_zero) begin
                    w_state_next = ST_PUMP;
                end else begin
                    w_settle_dec = 1'b1;
                end
            end
            ST_PUMP: begin
                // Stay one extra cycle after the final stroke so it is issued with the valve open.
                if (w_rem_zero) begin
                    w_dwell_load = 1'b1;
                    w_state_next = ST_DWELL;
                end else if (pump_ready) begin
                    w_pump_dec   = 1'b1;
                    w_pulse_next = 1'b1;
                end
            end
            ST_DWELL: begin
                if (w_dwell_zero) begin
                    w_state_next = ST_NEXT;
                end else begin
                    w_dwell_dec = 1'b1;
                end
            end
            ST_NEXT: begin
                if (r_cur_ch == CH_W'(N_REAGENTS - 1)) begin
`ifdef PCR_MIX_THERMAL_EN
                    w_state_next = ST_THERM;
`else
                    w_state_next = ST_DONE;
`endif
                end else begin
                    w_ch_next    = r_cur_ch + CH_W'(1);
                    w_sel_load   = 1'b1;
                    w_state_next = ST_SELECT;
                end
            end
            ST_THERM: begin
`ifdef PCR_MIX_THERMAL_EN
                if (r_cycle_cnt == r_n_cycles) begin
                    w_state_next = ST_DONE;
                end else if (r_therm_req && thermal_ack) begin
                    w_therm_inc = 1'b1;
                end else begin
                    w_req_next = 1'b1;
                end
`else
                w_state_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort wins over every other transition, including completion.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
            w_pulse_next = 1'b0;
            w_abort_take = 1'b1;
`ifdef PCR_MIX_THERMAL_EN
            w_therm_inc  = 1'b0;
            w_req_next   = 1'b0;
`endif
        end
    end

    assign w_valve_open = ((w_state_next == ST_SELECT) && (w_vol_next != '0)) ||
                          (w_state_next == ST_PUMP);
    assign w_done_next  = (w_state_next == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_vol_cfg    <= '0;
            r_dwell      <= '0;
            r_cur_ch     <= '0;
            r_valve_sel  <= '0;
            r_pump_pulse <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Configuration is captured as the run enters LOAD and then frozen.
            if ((r_state == ST_IDLE) && start) begin
                r_vol_cfg <= vol_cfg;
                r_dwell   <= dwell_cfg;
            end
            r_cur_ch     <= w_ch_next;
            r_valve_sel  <= w_valve_open ? w_onehot_next : '0;
            r_pump_pulse <= w_pulse_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= w_done_next;
            r_aborted    <= w_abort_take;
        end
    end

`ifdef PCR_MIX_THERMAL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n_cycles  <= '0;
            r_cycle_cnt <= '0;
            r_therm_req <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_n_cycles <= n_cycles;
            end
            if (r_state == ST_LOAD) begin
                r_cycle_cnt <= '0;
            end else if (w_therm_inc) begin
                r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
            end
            r_therm_req <= w_req_next;
        end
    end

    assign thermal_req = r_therm_req;
    assign cycle_cnt   = r_cycle_cnt;
`else
    assign thermal_req = 1'b0;
    assign cycle_cnt   = '0;
`endif

    assign valve_sel  = r_valve_sel;
    assign pump_pulse = r_pump_pulse;
    assign busy       = r_busy;
    assign cur_ch     = r_cur_ch;
    assign done       = r_done;
    assign aborted    = r_aborted;

endmodule

// File: tb/tb_pcr_mix_sequencer.sv
// Scoreboard bench for pcr_mix_sequencer: stimulus queues expected pump/thermal/done/abort
// events, an independent monitor pops and compares them as the DUT emits them.
module tb_pcr_mix_sequencer;

    localparam int N       = 6;
    localparam int VOL_W   = 8;
    localparam int DWELL_W = 16;
    localparam int CYC_W   = 6;
    localparam int SETTLE  = 2;

    localparam int EV_PULSE = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ABORT = 3;
    localparam int EV_TREQ  = 4;

`ifdef PCR_MIX_THERMAL_EN
    localparam int T1_DONE_K = 72;
    localparam bit THERM_ON  = 1'b1;
`else
    localparam int T1_DONE_K = 71;
    localparam bit THERM_ON  = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [N*VOL_W-1:0]   vol_cfg = '0;
    logic [DWELL_W-1:0]   dwell_cfg = '0;
    logic [CYC_W-1:0]     n_cycles = '0;
    logic                 pump_ready = 1'b1;
    logic                 thermal_ack = 1'b0;
    logic [N-1:0]         valve_sel;
    logic                 pump_pulse;
    logic                 thermal_req;
    logic                 busy;
    logic [2:0]           cur_ch;
    logic [CYC_W-1:0]     cycle_cnt;
    logic                 done;
    logic                 aborted;

    pcr_mix_sequencer #(
        .N_REAGENTS (N),
        .VOL_W      (VOL_W),
        .DWELL_W    (DWELL_W),
        .CYC_W      (CYC_W),
        .SETTLE     (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .vol_cfg     (vol_cfg),
        .dwell_cfg   (dwell_cfg),
        .n_cycles    (n_cycles),
        .pump_ready  (pump_ready),
        .thermal_ack (thermal_ack),
        .valve_sel   (valve_sel),
        .pump_pulse  (pump_pulse),
        .thermal_req (thermal_req),
        .busy        (busy),
        .cur_ch      (cur_ch),
        .cycle_cnt   (cycle_cnt),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic push_pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) push_ev(EV_PULSE, 1 << ch);
    endtask

    task automatic expect_evt(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d required no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
        end
    endtask

    // Monitor: compares every emitted event against the scoreboard, plus safety invariants.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pump_pulse) expect_evt(EV_PULSE, int'(valve_sel));
            if (done) expect_evt(EV_DONE, int'(cur_ch) * 256 + int'(cycle_cnt));
            if (aborted) expect_evt(EV_ABORT, 0);
            if (thermal_req && !prev_req) expect_evt(EV_TREQ, int'(cycle_cnt));
            chk("valve_onehot0", int'($onehot0(valve_sel)), 1);
            if (pump_pulse) chk("pulse_with_valve_open", int'(valve_sel != '0), 1);
            if (thermal_req) chk("treq_valve_closed", int'(valve_sel), 0);
        end
        prev_req <= thermal_req;
    end

    // Heater model: acknowledge five cycles after the request is seen.
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            thermal_ack = 1'b0;
            ack_cnt     = 0;
        end else if (thermal_ack) begin
            thermal_ack = 1'b0;
            ack_cnt     = 0;
        end else if (thermal_req) begin
            ack_cnt++;
            if (ack_cnt == 5) thermal_ack = 1'b1;
        end
    end

    int first_pulse_k, done_k, abort_k, ab_set_k, ch0p, ch1p, npulse;
    bit saw_v4, saw_ch2, stall_bad, busy1;
    int valve2;

    task automatic cfg(input int a, input int b, input int c, input int d, input int e,
                       input int f, input int dw, input int nc);
        vol_cfg[0*VOL_W +: VOL_W] = VOL_W'(a);
        vol_cfg[1*VOL_W +: VOL_W] = VOL_W'(b);
        vol_cfg[2*VOL_W +: VOL_W] = VOL_W'(c);
        vol_cfg[3*VOL_W +: VOL_W] = VOL_W'(d);
        vol_cfg[4*VOL_W +: VOL_W] = VOL_W'(e);
        vol_cfg[5*VOL_W +: VOL_W] = VOL_W'(f);
        dwell_cfg = DWELL_W'(dw);
        n_cycles  = CYC_W'(nc);
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode: 0 plain, 1 toggle pump_ready on ch0, 2 abort in ch1 pump, 3 reset in ch1 dwell
    task automatic watch(input int mode, input int budget);
        int k;
        first_pulse_k = -1; done_k = -1; abort_k = -1; ab_set_k = -1;
        ch0p = 0; ch1p = 0; npulse = 0;
        saw_v4 = 0; saw_ch2 = 0; stall_bad = 0; busy1 = 0; valve2 = -1;
        k = 1;
        while (1) begin
            if (pump_pulse) begin
                npulse++;
                if (first_pulse_k < 0) first_pulse_k = k;
                if (valve_sel == 6'd1) ch0p++;
                if (valve_sel == 6'd2) ch1p++;
            end
            if (valve_sel == 6'd4) saw_v4 = 1;
            if (busy && cur_ch == 3'd2) saw_ch2 = 1;
            if (k == 1) busy1 = busy;
            if (k == 2) valve2 = int'(valve_sel);
            if (mode == 1) begin
                if (ch0p >= 1 && ch0p < 4 && valve_sel != 6'd1) stall_bad = 1;
                pump_ready = (valve_sel == 6'd1 && ch0p < 4) ? ~pump_ready : 1'b1;
            end
            if (mode == 3) begin
                if (k == 6) start = 1'b1;
                if (k == 7) start = 1'b0;
                if (ch1p == 2 && valve_sel == '0 && !pump_pulse) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    chk("reset_mid_run_outputs",
                        int'({valve_sel, pump_pulse, thermal_req, busy, cur_ch, cycle_cnt, done}), 0);
                    chk("reset_mid_run_no_abort", int'(aborted), 0);
                    rst_n = 1'b1;
                    return;
                end
            end
            if (mode == 2 && ab_set_k < 0 && pump_pulse && valve_sel == 6'd2) begin
                abort    = 1'b1;
                ab_set_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (aborted) begin
                abort_k = k;
                abort   = 1'b0;
                chk("abort_latency", k, ab_set_k + 1);
                chk("abort_valve_closed", int'(valve_sel), 0);
                chk("abort_busy_low", int'(busy), 0);
                chk("abort_no_pulse", int'(pump_pulse), 0);
                break;
            end
            if (k >= budget) begin
                total++;
                bad++;
                $display("FAIL watch_timeout: got no done/aborted after %0d cycles required one", k);
                break;
            end
            @(negedge clk);
            k++;
        end
        pump_ready = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        chk("idle_after_run", int'(busy), 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valve_sel", int'(valve_sel), 0);
        chk("rst_pump_pulse", int'(pump_pulse), 0);
        chk("rst_thermal_req", int'(thermal_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur_ch", int'(cur_ch), 0);
        chk("rst_cycle_cnt", int'(cycle_cnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        rst_n = 1'b1;

        // Volumes 1..6, dwell 4: 21 pulses in channel order, exact latencies
        cfg(1, 2, 3, 4, 5, 6, 4, 0);
        for (int ch = 0; ch < N; ch++) push_pulses(ch, ch + 1);
        push_ev(EV_DONE, 5 * 256);
        launch();
        watch(0, 400);
        chk("t1_busy_at_t1", int'(busy1), 1);
        chk("t1_valve_at_t2", valve2, 1);
        chk("t1_first_pulse_cycle", first_pulse_k, 2 + SETTLE + 1);
        chk("t1_done_cycle", done_k, T1_DONE_K);
        chk("t1_total_pulses", npulse, 21);
        drain("t1_queue_empty");

        // Zero-volume channel is skipped with the valve closed
        cfg(3, 3, 0, 3, 3, 3, 1, 0);
        for (int ch = 0; ch < N; ch++) if (ch != 2) push_pulses(ch, 3);
        push_ev(EV_DONE, 5 * 256);
        launch();
        watch(0, 400);
        chk("t2_valve4_never", int'(saw_v4), 0);
        chk("t2_cur_ch_passed_2", int'(saw_ch2), 1);
        chk("t2_total_pulses", npulse, 15);
        drain("t2_queue_empty");

        // pump_ready stalls during ch0: exactly 4 strokes, valve held open
        cfg(4, 1, 1, 1, 1, 1, 2, 0);
        push_pulses(0, 4);
        for (int ch = 1; ch < N; ch++) push_pulses(ch, 1);
        push_ev(EV_DONE, 5 * 256);
        launch();
        watch(1, 400);
        chk("t3_valve_held_in_stall", int'(stall_bad), 0);
        chk("t3_ch0_pulses", ch0p, 4);
        drain("t3_queue_empty");

        // Thermal stage with three cycles (absent when compiled out), dwell 0 pass-through
        cfg(1, 1, 1, 1, 1, 1, 0, 3);
        for (int ch = 0; ch < N; ch++) push_pulses(ch, 1);
        if (THERM_ON) begin
            for (int c = 0; c < 3; c++) push_ev(EV_TREQ, c);
            push_ev(EV_DONE, 5 * 256 + 3);
        end else begin
            push_ev(EV_DONE, 5 * 256);
        end
        launch();
        watch(0, 400);
        chk("t4_total_pulses", npulse, 6);
        drain("t4_queue_empty");

        // Abort two cycles into ch1 pump, then a clean restart from ch0
        cfg(3, 3, 3, 3, 3, 3, 2, 0);
        push_pulses(0, 3);
        push_pulses(1, 1);
        push_ev(EV_ABORT, 0);
        launch();
        watch(2, 400);
        chk("t5_abort_seen", int'(abort_k > 0), 1);
        chk("t5_no_done", done_k, -1);
        drain("t5_queue_empty");
        cfg(1, 1, 1, 1, 1, 1, 0, 0);
        for (int ch = 0; ch < N; ch++) push_pulses(ch, 1);
        push_ev(EV_DONE, 5 * 256);
        launch();
        watch(0, 400);
        chk("t5b_restart_valve_ch0", valve2, 1);
        drain("t5b_queue_empty");

        // Start while busy is ignored; reset during ch1 dwell clears everything
        cfg(2, 2, 2, 2, 2, 2, 4, 0);
        push_pulses(0, 2);
        push_pulses(1, 2);
        launch();
        watch(3, 400);
        drain("t6_queue_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
